// File: rtl/hazard_io_pkg.sv
// hazard_io: shared types, constants and forwarding helper for the multi-cycle hazard unit
//  hazard_mc_in  : D/E/M/W register indices, load-in-E flag, branch-taken, stage write enables
//  hazard_mc_out : stall/flush controls and E-stage forward selects
package hazard_io;

    localparam int REG_W    = 5;
    localparam int MD_CNT_W = 4;

    typedef enum logic [1:0] {MD_IDLE, MD_RUN, MD_WB} md_state_t;

    typedef struct packed {
        logic [REG_W-1:0] rs1d;
        logic [REG_W-1:0] rs2d;
        logic [REG_W-1:0] rs1e;
        logic [REG_W-1:0] rs2e;
        logic [REG_W-1:0] rde;
        logic [REG_W-1:0] rdm;
        logic [REG_W-1:0] rdw;
        logic             result_src_e_zero;
        logic             pc_src_e;
        logic             reg_write_e;
        logic             reg_write_m;
        logic             reg_write_w;
    } hazard_mc_in;

    typedef struct packed {
        logic       stall_f;
        logic       stall_d;
        logic       flush_d;
        logic       flush_e;
        logic [1:0] forward_ae;
        logic [1:0] forward_be;
    } hazard_mc_out;

    // M has priority over W because it holds the younger result
    function automatic logic [1:0] fwd_sel(
        input logic [REG_W-1:0] rs,
        input logic [REG_W-1:0] rdm,
        input logic [REG_W-1:0] rdw,
        input logic             wm,
        input logic             ww
    );
        return (rs == '0)           ? 2'b00 :
               (wm && rdm == rs)    ? 2'b10 :
               (ww && rdw == rs)    ? 2'b01 : 2'b00;
    endfunction

endpackage

// File: rtl/hazard_unit_mc_md_scoreboard.sv
// md_scoreboard: MD sequencer FSM with per-register pending bits
//  i_start/i_rd   : MD op valid in E and its destination
//  i_flush        : branch taken in E, suppresses issue
//  i_md_in_d      : MD op waiting in D
//  i_rs1d/i_rs2d  : D-stage source registers
//  o_busy, o_wb_valid, o_wb_rd : sequencer status and writeback pulse
//  o_sb_stall, o_md_stall      : D-stage stall requests
module md_scoreboard
    import hazard_io::*;
#(
    parameter int NREGS      = 32,
    parameter int MD_LATENCY = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [REG_W-1:0] i_rd,
    input  logic             i_flush,
    input  logic             i_md_in_d,
    input  logic [REG_W-1:0] i_rs1d,
    input  logic [REG_W-1:0] i_rs2d,
    output logic             o_busy,
    output logic             o_wb_valid,
    output logic [REG_W-1:0] o_wb_rd,
    output logic             o_sb_stall,
    output logic             o_md_stall
);

    md_state_t            r_state;
    logic [MD_CNT_W-1:0]  r_cnt;
    logic [NREGS-1:0]     r_pending;
    logic [REG_W-1:0]     r_rd;
    logic                 r_busy;
    logic                 r_wb_valid;

    // RUN lasts MD_LATENCY-1 cycles so WB lands MD_LATENCY cycles after issue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= MD_IDLE;
            r_cnt      <= '0;
            r_pending  <= '0;
            r_rd       <= '0;
            r_busy     <= 1'b0;
            r_wb_valid <= 1'b0;
        end else begin
            case (r_state)
                MD_IDLE: if (i_start && !i_flush) begin
                    r_cnt   <= MD_CNT_W'(MD_LATENCY - 1);
                    r_rd    <= i_rd;
                    r_busy  <= 1'b1;
                    r_state <= MD_RUN;
                    if (i_rd != '0) r_pending[i_rd] <= 1'b1;
                end
                MD_RUN: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == MD_CNT_W'(1)) begin
                        r_state    <= MD_WB;
                        r_wb_valid <= 1'b1;
                    end
                end
                MD_WB: begin
                    r_pending[r_rd] <= 1'b0;
                    r_wb_valid      <= 1'b0;
                    r_busy          <= 1'b0;
                    r_state         <= MD_IDLE;
                end
                default: r_state <= MD_IDLE;
            endcase
        end
    end

    assign o_busy     = r_busy;
    assign o_wb_valid = r_wb_valid;
    assign o_wb_rd    = r_rd;
    assign o_sb_stall = r_pending[i_rs1d] | r_pending[i_rs2d];
    assign o_md_stall = i_md_in_d & r_busy;

endmodule

// File: rtl/hazard_unit_mc.sv
// hazard_unit_mc: forwarding, load-use / scoreboard / MD stalls and branch flush for the 5-stage core
//  clk, rst_n   : clock, asynchronous active-low reset
//  hz_i         : pipeline register indices and control bits
//  md_start_e, md_rd_e, md_in_d : MD issue in E, its destination, MD op in D
//  hz_o         : StallF/StallD/FlushD/FlushE/ForwardAE/ForwardBE
//  md_busy, md_wb_valid, md_wb_rd : MD sequencer status and writeback
module hazard_unit_mc
    import hazard_io::*;
#(
    parameter int NREGS      = 32,
    parameter int MD_LATENCY = 4,
    parameter int FWD_EN     = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  hazard_mc_in      hz_i,
    input  logic             md_start_e,
    input  logic [REG_W-1:0] md_rd_e,
    input  logic             md_in_d,
    output hazard_mc_out     hz_o,
    output logic             md_busy,
    output logic             md_wb_valid,
    output logic [REG_W-1:0] md_wb_rd
);

    logic w_sb_stall;
    logic w_md_stall;
    logic w_lw_stall;
    logic w_nofwd_stall;
    logic w_any_stall;

    md_scoreboard #(
        .NREGS      (NREGS),
        .MD_LATENCY (MD_LATENCY)
    ) u_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_start    (md_start_e),
        .i_rd       (md_rd_e),
        .i_flush    (hz_i.pc_src_e),
        .i_md_in_d  (md_in_d),
        .i_rs1d     (hz_i.rs1d),
        .i_rs2d     (hz_i.rs2d),
        .o_busy     (md_busy),
        .o_wb_valid (md_wb_valid),
        .o_wb_rd    (md_wb_rd),
        .o_sb_stall (w_sb_stall),
        .o_md_stall (w_md_stall)
    );

    function automatic logic raw(input logic [REG_W-1:0] rs, input hazard_mc_in h);
        return (rs != '0) && ((h.reg_write_e && h.rde == rs) ||
                              (h.reg_write_m && h.rdm == rs) ||
                              (h.reg_write_w && h.rdw == rs));
    endfunction

    assign w_lw_stall    = hz_i.result_src_e_zero && hz_i.rde != '0 &&
                           (hz_i.rde == hz_i.rs1d || hz_i.rde == hz_i.rs2d);
    assign w_nofwd_stall = (FWD_EN == 0) && (raw(hz_i.rs1d, hz_i) || raw(hz_i.rs2d, hz_i));
    assign w_any_stall   = w_lw_stall | w_sb_stall | w_md_stall | w_nofwd_stall;

    // Outputs are held at zero while reset is asserted, whatever the inputs
    always_comb begin
        hz_o = '0;
        if (rst_n) begin
            hz_o.stall_f    = w_any_stall;
            hz_o.stall_d    = w_any_stall;
            hz_o.flush_d    = hz_i.pc_src_e;
            hz_o.flush_e    = w_any_stall | hz_i.pc_src_e;
            hz_o.forward_ae = (FWD_EN != 0) ? fwd_sel(hz_i.rs1e, hz_i.rdm, hz_i.rdw, hz_i.reg_write_m, hz_i.reg_write_w) : 2'b00;
            hz_o.forward_be = (FWD_EN != 0) ? fwd_sel(hz_i.rs2e, hz_i.rdm, hz_i.rdw, hz_i.reg_write_m, hz_i.reg_write_w) : 2'b00;
        end
    end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// tb_hazard_unit_mc: directed self-checking bench for hazard_unit_mc
module tb_hazard_unit_mc;
    import hazard_io::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    hazard_mc_in  hz;
    logic         md_start_e;
    logic [4:0]   md_rd_e;
    logic         md_in_d;
    hazard_mc_out hz_o;
    logic         md_busy;
    logic         md_wb_valid;
    logic [4:0]   md_wb_rd;
    int           checks = 0;
    int           failures = 0;

    hazard_unit_mc #(.NREGS(32), .MD_LATENCY(4), .FWD_EN(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .hz_i        (hz),
        .md_start_e  (md_start_e),
        .md_rd_e     (md_rd_e),
        .md_in_d     (md_in_d),
        .hz_o        (hz_o),
        .md_busy     (md_busy),
        .md_wb_valid (md_wb_valid),
        .md_wb_rd    (md_wb_rd)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && md_start_e && md_busy) begin
            checks++;
            assert (0) else begin
                failures++;
                $error("FAIL start_while_busy obs=1 exp=0");
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic clr;
        hz         = '0;
        md_start_e = 1'b0;
        md_rd_e    = '0;
        md_in_d    = 1'b0;
    endtask

    initial begin
        clr();
        hz.pc_src_e = 1'b1;
        #2;
        chk("rst_busy", md_busy, 0);
        chk("rst_wb_valid", md_wb_valid, 0);
        chk("rst_wb_rd", md_wb_rd, 0);
        chk("rst_hz_o", hz_o, 0);
        clr();
        tick();
        rst_n = 1'b1;
        #1;
        // forwarding priority and x0
        hz.rdm = 5; hz.rdw = 5; hz.reg_write_m = 1; hz.reg_write_w = 1; hz.rs1e = 5; hz.rs2e = 5;
        #1;
        chk("fwd_a_m", hz_o.forward_ae, 2'b10);
        chk("fwd_b_m", hz_o.forward_be, 2'b10);
        hz.reg_write_m = 0;
        #1;
        chk("fwd_a_w", hz_o.forward_ae, 2'b01);
        hz.rs1e = 0;
        #1;
        chk("fwd_a_x0", hz_o.forward_ae, 2'b00);
        chk("fwd_no_stall", hz_o.stall_d, 0);
        // load-use
        tick(); clr();
        hz.result_src_e_zero = 1; hz.rde = 7; hz.rs2d = 7;
        #1;
        chk("lw_stall_f", hz_o.stall_f, 1);
        chk("lw_stall_d", hz_o.stall_d, 1);
        chk("lw_flush_e", hz_o.flush_e, 1);
        chk("lw_flush_d", hz_o.flush_d, 0);
        tick(); clr();
        hz.rs2d = 7;
        #1;
        chk("lw_released", hz_o.stall_d, 0);
        hz.result_src_e_zero = 1; hz.rde = 0; hz.rs1d = 0;
        #1;
        chk("lw_x0", hz_o.stall_d, 0);
        hz.rde = 7; hz.pc_src_e = 1;
        #1;
        chk("lw_br_flush_d", hz_o.flush_d, 1);
        chk("lw_br_flush_e", hz_o.flush_e, 1);
        chk("lw_br_stall_f", hz_o.stall_f, 1);
        // MD issue rd=9, dependent read held in D
        tick(); clr();
        md_start_e = 1; md_rd_e = 9;
        #1;
        chk("md_pre_busy", md_busy, 0);
        tick(); clr();
        hz.rs1d = 9;
        for (int c = 1; c <= 4; c++) begin
            #1;
            chk($sformatf("md_stall_c%0d", c), hz_o.stall_d, 1);
            chk($sformatf("md_busy_c%0d", c), md_busy, 1);
            chk($sformatf("md_wbv_c%0d", c), md_wb_valid, (c == 4) ? 1 : 0);
            if (c == 4) chk("md_wb_rd", md_wb_rd, 9);
            tick();
        end
        #1;
        chk("md_stall_c5", hz_o.stall_d, 0);
        chk("md_busy_c5", md_busy, 0);
        chk("md_wbv_c5", md_wb_valid, 0);
        // second MD op waits in D
        tick(); clr();
        md_start_e = 1; md_rd_e = 3;
        tick(); clr();
        md_in_d = 1;
        for (int c = 1; c <= 4; c++) begin
            #1;
            chk($sformatf("md2_stall_c%0d", c), hz_o.stall_d, 1);
            tick();
        end
        #1;
        chk("md2_released", hz_o.stall_d, 0);
        tick(); clr();
        md_start_e = 1; md_rd_e = 10;
        #1;
        chk("md2_issue_idle", md_busy, 0);
        tick(); clr();
        hz.rs2d = 10;
        #1;
        chk("md2_busy", md_busy, 1);
        chk("md2_sb_stall", hz_o.stall_d, 1);
        tick(); tick(); tick();
        #1;
        chk("md2_wbv", md_wb_valid, 1);
        chk("md2_wb_rd", md_wb_rd, 10);
        tick(); clr();
        // issue suppressed by branch
        md_start_e = 1; md_rd_e = 12; hz.pc_src_e = 1;
        #1;
        chk("br_flush_d", hz_o.flush_d, 1);
        chk("br_flush_e", hz_o.flush_e, 1);
        chk("br_stall_d", hz_o.stall_d, 0);
        tick(); clr();
        hz.rs1d = 12;
        #1;
        chk("br_no_busy", md_busy, 0);
        chk("br_no_pending", hz_o.stall_d, 0);
        // reset mid-RUN
        tick(); clr();
        md_start_e = 1; md_rd_e = 6;
        tick(); clr();
        hz.rs1d = 6;
        tick();
        #1;
        chk("rr_stall", hz_o.stall_d, 1);
        rst_n = 1'b0;
        #1;
        chk("rr_busy", md_busy, 0);
        chk("rr_wbv", md_wb_valid, 0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("rr_pending", hz_o.stall_d, 0);
        for (int c = 0; c < 6; c++) begin
            tick();
            chk($sformatf("rr_no_wb_%0d", c), md_wb_valid, 0);
            chk($sformatf("rr_idle_%0d", c), md_busy, 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
